// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : Chain of STAGES data registers, each with a valid bit, under
//               valid/ready flow control. Empty stages (bubbles) compact: a
//               stage advances when it is empty or the stage after it
//               advances. Provides flush (drops all entries) and a registered
//               occupancy count.
//
//               Optional feature macro: PIPE_SKID_EN
//                 defined   - a one-entry skid register in front of stage 0.
//                             in_ready is then driven from the skid valid
//                             register, so it has no combinational path from
//                             out_ready. Capacity becomes STAGES+1.
//                 undefined - no skid; in_ready depends on out_ready through
//                             the stage-advance chain. Capacity is STAGES.
//
// Ports       : clk        rising-edge clock
//               reset      synchronous, active-high reset
//               flush      clear all valid bits on the next edge
//               in_valid   upstream presents in_data
//               in_ready   chain accepts in_data this cycle
//               in_data    payload in [WIDTH]
//               out_valid  last stage holds valid data
//               out_ready  downstream takes out_data this cycle
//               out_data   last-stage payload [WIDTH]
//               occupancy  number of valid entries held [$clog2(STAGES+2)]
//
// Revision    : 1.0  initial release
// ============================================================================
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES + 2);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  // Stage-advance flags and the word offered to stage 0.
  logic [STAGES-1:0] adv;
  logic              src_v;
  logic [WIDTH-1:0]  src_d;
  logic              occ_extra;

  // Stage k advances when out_ready is high or any stage from k to the
  // output is empty. Written as a mask test rather than a ripple so the
  // flag vector never depends on itself.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      logic [STAGES-1:0] mask;
      mask   = {STAGES{1'b1}} << k;
      adv[k] = out_ready | ((v_q & mask) != mask);
    end
  end

`ifdef PIPE_SKID_EN
  logic             skid_v_q;
  logic             skid_v_d;
  logic [WIDTH-1:0] skid_d_q;
  logic [WIDTH-1:0] skid_d_d;

  assign in_ready  = !skid_v_q && !flush;
  // A parked word goes ahead of new input; while parked, in_ready is low so
  // no new word can arrive in the same cycle.
  assign src_v     = skid_v_q | in_valid;
  assign src_d     = skid_v_q ? skid_d_q : in_data;
  assign occ_extra = skid_v_d;

  always_comb begin
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (adv[0]) begin
        skid_v_d = 1'b0;
      end
    end else if (in_valid && !adv[0]) begin
      skid_v_d = 1'b1;
      skid_d_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_v_q <= 1'b0;
      skid_d_q <= RESET_VAL;
    end else begin
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end
`else
  assign in_ready  = adv[0] && !flush;
  assign src_v     = in_valid;
  assign src_d     = in_data;
  assign occ_extra = 1'b0;
`endif

  // Next state: flush drops every valid bit but leaves data untouched.
  // Data only moves forward out of a valid stage, so bubbles keep their
  // previous payload and a stalled stage is never overwritten.
  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      d_d[k] = d_q[k];
    end
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = src_v;
        if (src_v) begin
          d_d[0] = src_d;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = d_q[k-1];
          end
        end
      end
    end
    occ_d = OCC_W'(occ_extra);
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        d_q[k] <= RESET_VAL;
      end else begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule
`default_nettype wire
